serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor.
// One full adder and one carry flip-flop process the operands LSB first,
// one bit per clock. Subtraction is a + ~b + 1: the B operand is inverted
// when it is latched and the carry is preloaded with 1.
//
// Handshake: an operation is accepted on any rising edge where start=1 and
// the block is not busy (IDLE or DONE state). busy is high for exactly WIDTH
// cycles, then done pulses for one cycle with sum/cout/overflow valid. The
// results stay stable until the next accepted start. Starts seen while busy
// are ignored.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic             sum_bit_d;
    logic             carry_d;

    // The single 1-bit full adder working on the current operand LSBs.
    always_comb begin
        sum_bit_d = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    end

    // Control FSM and serial datapath with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Result bits enter at the MSB end so that after WIDTH
                    // shifts bit 0 has reached position 0.
                    sum_q   <= {sum_bit_d, sum_q[WIDTH-1:1]};
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        // carry_q is the carry into the MSB at this point.
                        cout_q  <= carry_d;
                        ovf_q   <= carry_q ^ carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Back-to-back: accept immediately, no idle cycle.
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule
